// File: rtl/sigplayback.sv
// Triggered capture-and-playback buffer: records a window of mic samples into a
// dual-port RAM, then streams them out over valid/ready, once or looped.
module sigplayback #(
  parameter int unsigned ADDRESS_WIDTH = 9,
  parameter int unsigned DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [DATA_WIDTH-1:0]    mic_signal,
  input  logic                     trigger,
  input  logic [ADDRESS_WIDTH-1:0] length,
  input  logic                     loop,
  input  logic                     abort,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned AW    = ADDRESS_WIDTH;
  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned LW    = ADDRESS_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    PLAY    = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          pend_q, pend_d;
  logic          final_q, final_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic [DW-1:0] data_q;

  logic [DW-1:0] mem [DEPTH];

  logic last_wr_c;
  logic last_rd_c;
  logic issue_c;
  logic accept_c;
  logic wr_en_c;
  logic rd_en_c;

  assign last_wr_c = ({1'b0, wr_ptr_q} == (len_q - LW'(1)));
  assign last_rd_c = ({1'b0, rd_ptr_q} == (len_q - LW'(1)));
  assign issue_c   = (state_q == PLAY) && pend_q && (!valid_q || out_ready);
  assign accept_c  = valid_q && out_ready;
  assign wr_en_c   = (state_q == CAPTURE) && en && !abort;
  assign rd_en_c   = issue_c && !abort;

  // Next-state and datapath control; abort overrides everything else.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pend_d   = pend_q;
    final_d  = final_q;
    valid_d  = valid_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (trigger) begin
          len_d    = (length == '0) ? LW'(DEPTH) : {1'b0, length};
          wr_ptr_d = '0;
          state_d  = CAPTURE;
        end
      end
      CAPTURE: begin
        if (en) begin
          wr_ptr_d = wr_ptr_q + AW'(1);
          if (last_wr_c) begin
            state_d  = PLAY;
            rd_ptr_d = '0;
            pend_d   = 1'b1;
            final_d  = 1'b0;
          end
        end
      end
      PLAY: begin
        if (issue_c) begin
          valid_d = 1'b1;
          if (last_rd_c) begin
            rd_ptr_d = '0;
            if (!loop) begin
              pend_d  = 1'b0;
              final_d = 1'b1;
            end
          end else begin
            rd_ptr_d = rd_ptr_q + AW'(1);
          end
        end else if (accept_c) begin
          valid_d = 1'b0;
        end
        // final_q marks that the word on out_data is the last of the window
        if (accept_c && final_q) begin
          done_d  = 1'b1;
          final_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d = IDLE;
      valid_d = 1'b0;
      done_d  = 1'b0;
      pend_d  = 1'b0;
      final_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  // State and control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      len_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pend_q   <= 1'b0;
      final_q  <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pend_q   <= pend_d;
      final_q  <= final_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_ptr_q] <= mic_signal;
    end
  end

  // RAM read port doubles as the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (rd_en_c) begin
      data_q <= mem[rd_ptr_q];
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sigplayback.sv
// Self-checking bench for sigplayback: vector table plus hand-written reset,
// abort and full-depth sequences, with an output scoreboard.
module tb_sigplayback;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [DW-1:0] mic_signal;
  logic          trigger;
  logic [AW-1:0] length;
  logic          loop;
  logic          abort;
  logic          out_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;

  sigplayback #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .en(en), .mic_signal(mic_signal), .trigger(trigger),
    .length(length), .loop(loop), .abort(abort), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]    len;
    int unsigned      nsamp;
    logic [5:0][7:0]  data;
    logic [5:0]       en_pat;
    int unsigned      loops;
    logic [7:0]       rdy_pat;
    int unsigned      exp_n;
    logic [8:0][7:0]  exp;
    logic             contig;
  } vec_t;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          last;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   hs_cnt = 0;
  int   done_cnt = 0;
  int   run_len = 0;
  int   last_run = 0;
  logic mon_en = 1'b0;
  logic exp_done = 1'b0;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Output monitor: scoreboard pops, stall stability, done timing.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_done) begin
        n_chk++;
        if (!(done === 1'b1 && busy === 1'b0)) begin
          n_fail++;
          $display("FAIL done_pulse: done=%b busy=%b, required done=1 busy=0", done, busy);
        end
        exp_done = 1'b0;
      end else if (done !== 1'b0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_done: done=%b, required 0", done);
      end
      if (done === 1'b1) done_cnt++;
      if (prev_stall && out_valid === 1'b1) begin
        n_chk++;
        if (out_data !== prev_data) begin
          n_fail++;
          $display("FAIL stall_hold: out_data=%0d, required %0d", out_data, prev_data);
        end
      end
      run_len = (out_valid === 1'b1) ? run_len + 1 : 0;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        hs_cnt++;
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: out_data=%0d, required no output", out_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (out_data !== e.d) begin
            n_fail++;
            $display("FAIL playback_data: got %0d, required %0d", out_data, e.d);
          end
          if (e.last) begin
            exp_done = 1'b1;
            last_run = run_len;
          end
        end
      end
      prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
      prev_data  = out_data;
    end
  end

  // Drains playback until done, steering out_ready and loop; bounded.
  task automatic wait_playback(input int base, input int dbase, input logic [7:0] rdy_pat,
                               input int drop_at, input int budget);
    int rp;
    int cyc;
    rp  = 0;
    cyc = 0;
    while (done_cnt == dbase && cyc < budget) begin
      @(posedge clk); #1;
      if (cyc == 0) chk("first_valid", 32'(out_valid), 32'd1);
      if (out_valid) begin
        out_ready = (rp < 8) ? rdy_pat[rp] : 1'b1;
        rp++;
      end else begin
        out_ready = 1'b1;
      end
      if (hs_cnt - base >= drop_at) loop = 1'b0;
      cyc++;
    end
    chk("done_seen", 32'(done_cnt - dbase), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int base;
    int dbase;
    exp_t e;
    @(posedge clk); #1;
    length    = v.len;
    trigger   = 1'b1;
    loop      = (v.loops != 0);
    out_ready = 1'b1;
    base      = hs_cnt;
    dbase     = done_cnt;
    for (int j = 0; j < int'(v.exp_n); j++) begin
      e.d    = v.exp[j];
      e.last = (j == int'(v.exp_n) - 1);
      sb.push_back(e);
    end
    for (int i = 0; i < int'(v.nsamp); i++) begin
      @(posedge clk); #1;
      if (i == 0) chk("busy_after_trigger", 32'(busy), 32'd1);
      trigger    = 1'b0;
      en         = v.en_pat[i];
      mic_signal = v.data[i];
    end
    @(posedge clk); #1;
    en = 1'b0;
    chk("first_read_latency", 32'({busy, out_valid}), 32'b10);
    wait_playback(base, dbase, v.rdy_pat, int'(v.loops * 32'(v.len)), 300);
    chk("accepted_count", 32'(hs_cnt - base), v.exp_n);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    if (v.contig) chk("no_bubble_run", 32'(last_run), v.exp_n);
  endtask

  vec_t tbl[4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int dbase;
    int cyc;
    exp_t e;

    for (int k = 0; k < 4; k++) tbl[k] = '0;
    tbl[0].len = 9'd4; tbl[0].nsamp = 4; tbl[0].en_pat = 6'b001111;
    tbl[0].data[0] = 8'd10; tbl[0].data[1] = 8'd20; tbl[0].data[2] = 8'd30; tbl[0].data[3] = 8'd40;
    tbl[0].rdy_pat = 8'hFF; tbl[0].exp_n = 4; tbl[0].contig = 1'b1;
    tbl[0].exp[0] = 8'd10; tbl[0].exp[1] = 8'd20; tbl[0].exp[2] = 8'd30; tbl[0].exp[3] = 8'd40;

    tbl[1].len = 9'd3; tbl[1].nsamp = 6; tbl[1].en_pat = 6'b100101;
    tbl[1].data[0] = 8'd5; tbl[1].data[1] = 8'd99; tbl[1].data[2] = 8'd6;
    tbl[1].data[3] = 8'd98; tbl[1].data[4] = 8'd97; tbl[1].data[5] = 8'd7;
    tbl[1].rdy_pat = 8'hFF; tbl[1].exp_n = 3; tbl[1].contig = 1'b1;
    tbl[1].exp[0] = 8'd5; tbl[1].exp[1] = 8'd6; tbl[1].exp[2] = 8'd7;

    tbl[2].len = 9'd4; tbl[2].nsamp = 4; tbl[2].en_pat = 6'b001111;
    tbl[2].data[0] = 8'd1; tbl[2].data[1] = 8'd2; tbl[2].data[2] = 8'd3; tbl[2].data[3] = 8'd4;
    tbl[2].rdy_pat = 8'b11101001; tbl[2].exp_n = 4; tbl[2].contig = 1'b0;
    tbl[2].exp[0] = 8'd1; tbl[2].exp[1] = 8'd2; tbl[2].exp[2] = 8'd3; tbl[2].exp[3] = 8'd4;

    tbl[3].len = 9'd3; tbl[3].nsamp = 3; tbl[3].en_pat = 6'b000111; tbl[3].loops = 2;
    tbl[3].data[0] = 8'd8; tbl[3].data[1] = 8'd9; tbl[3].data[2] = 8'd10;
    tbl[3].rdy_pat = 8'hFF; tbl[3].exp_n = 9; tbl[3].contig = 1'b1;
    for (int j = 0; j < 9; j++) tbl[3].exp[j] = 8'(8 + (j % 3));

    rst = 1'b1; en = 1'b0; mic_signal = '0; trigger = 1'b0; length = '0;
    loop = 1'b0; abort = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 32'({out_valid, busy, done, out_data}), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Reset asserted for two cycles while a sample is waiting in PLAY.
    @(posedge clk); #1;
    length = 9'd4; trigger = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      trigger = 1'b0; en = 1'b1; mic_signal = 8'(60 + i);
    end
    @(posedge clk); #1;
    en = 1'b0;
    @(posedge clk); #1;
    chk("valid_before_rst", 32'({busy, out_valid}), 32'b11);
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_in_play", 32'({out_valid, busy, done, out_data}), 32'd0);
    out_ready = 1'b1;

    for (int k = 0; k < 4; k++) run_vec(tbl[k]);

    // Full-depth window via length=0.
    @(posedge clk); #1;
    length = '0; trigger = 1'b1; loop = 1'b0; out_ready = 1'b1;
    base = hs_cnt; dbase = done_cnt;
    for (int i = 0; i < 512; i++) begin
      e.d = 8'(i * 7 + 3);
      e.last = (i == 511);
      sb.push_back(e);
    end
    for (int i = 0; i < 512; i++) begin
      @(posedge clk); #1;
      trigger = 1'b0; en = 1'b1; mic_signal = 8'(i * 7 + 3);
    end
    @(posedge clk); #1;
    en = 1'b0;
    chk("full_first_read_latency", 32'({busy, out_valid}), 32'b10);
    wait_playback(base, dbase, 8'hFF, 0, 700);
    chk("full_accepted", 32'(hs_cnt - base), 32'd512);
    chk("full_no_bubble", 32'(last_run), 32'd512);
    chk("full_sb_empty", 32'(sb.size()), 32'd0);

    // Abort after two accepted samples; no done pulse.
    @(posedge clk); #1;
    length = 9'd4; trigger = 1'b1; out_ready = 1'b1;
    base = hs_cnt;
    for (int i = 0; i < 2; i++) begin
      e.d = 8'(50 + i);
      e.last = 1'b0;
      sb.push_back(e);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      trigger = 1'b0; en = 1'b1; mic_signal = 8'(50 + i);
    end
    @(posedge clk); #1;
    en = 1'b0;
    cyc = 0;
    while (hs_cnt - base < 2 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("abort_two_accepted", 32'(hs_cnt - base), 32'd2);
    abort = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_idle", 32'({out_valid, busy, done}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", 32'({busy, done}), 32'd0);
    end
    chk("abort_sb_empty", 32'(sb.size()), 32'd0);
    trigger = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b0; abort = 1'b0;
    chk("abort_beats_trigger", 32'(busy), 32'd0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
